// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int INS_W  = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INS_W-1:0]  ins;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Saturating 32-bit add used by the optional performance counters.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched instructions; the head entry feeds decode.
// Push and pop may coincide at any occupancy, flush empties it at once.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entry_q [2];
    fetch_entry_t entry_d [2];
    logic         rd_ptr_q;
    logic         rd_ptr_d;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         wr_ptr;

    // The write slot sits count entries past the read pointer, modulo two.
    assign wr_ptr = rd_ptr_q ^ count_q[0];
    assign count  = count_q;
    assign head   = (count_q != 2'd0) ? entry_q[rd_ptr_q] : '0;

    // Next-state computation for storage, read pointer and occupancy.
    always_comb begin
        entry_d  = entry_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                entry_d[wr_ptr] = push_entry;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            entry_q  <= entry_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word addresses to a memory with one
// cycle of read latency, buffers returned words and hands them to decode
// over valid/ready. Handles redirects and halts at the end of the image.
// Optional build macro FETCH_PERF_CNT_EN adds stall/flush counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PROG_LEN = 25,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INS_W-1:0]  ins,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INS_W-1:0]  id_ins,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_flush
`endif
);

    localparam logic [ADDR_W:0]   PROG_END   = PROG_LEN[ADDR_W:0];
    localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC[ADDR_W-1:0];

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              inflight_q;
    logic              inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [ADDR_W-1:0] inflight_pc_d;

    logic [1:0]        buf_count;
    fetch_entry_t      buf_head;
    fetch_entry_t      push_entry;
    logic              push;
    logic              pop;
    logic              issue;
    logic              pc_below_end;
    logic [2:0]        occupancy;
    logic [1:0]        count_next;

    assign mem_addr     = pc_q;
    assign id_valid     = (buf_count != 2'd0);
    assign id_ins       = buf_head.ins;
    assign id_pc        = buf_head.pc;
    assign halted       = (state_q == HALT);

    assign pop          = id_valid && id_ready;
    assign push         = inflight_q && !redirect_valid;
    assign push_entry   = '{ins: ins, pc: inflight_pc_q};
    assign pc_below_end = ({1'b0, pc_q} < PROG_END);
    assign occupancy    = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue        = (state_q == RUN) && pc_below_end && !redirect_valid && (occupancy < 3'd2);
    assign count_next   = buf_count + {1'b0, push} - {1'b0, pop};

    fetch_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (buf_count),
        .head       (buf_head)
    );

    // Issue, redirect and halt decisions; HALT is entered on the same edge the
    // last entry leaves so halted rises the cycle after the final handshake.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = RUN;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + ADDR_W'(1);
            end
            if ((state_q == RUN) && ({1'b0, pc_d} >= PROG_END) && !inflight_d && (count_next == 2'd0)) begin
                state_d = HALT;
            end
        end
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_ADDR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_flush_d;
    logic [31:0] discard;

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
    // A head accepted in the redirect cycle is delivered, not discarded.
    assign discard    = 32'(buf_count) + 32'(inflight_q) - 32'(pop);

    // Saturating counts of back-pressured cycles and flushed entries.
    always_comb begin
        perf_stall_d = sat_add(perf_stall_q, 32'(id_valid && !id_ready));
        perf_flush_d = perf_flush_q;
        if (redirect_valid) begin
            perf_flush_d = sat_add(perf_flush_q, discard);
        end
    end

    // Performance counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized ready/redirect/reset traffic.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int PROG_LEN = 25;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] mem_addr;
    logic [INS_W-1:0]  ins;
    logic              id_valid;
    logic              id_ready;
    logic [INS_W-1:0]  id_ins;
    logic [ADDR_W-1:0] id_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_stall;
    logic [31:0]       perf_flush;
`endif

    int  vectors     = 0;
    int  miscompares = 0;
    bit  chk_en      = 0;

    // Reference model state: fetch pointer, one optional in-flight pc and
    // a queue of buffered pcs; instruction words are derived from the pc.
    int      m_pc;
    bit      m_infl;
    int      m_infl_pc;
    int      m_buf_pc[$];
    bit      m_halt;
    longint  m_stall;
    longint  m_flush;

    fetch_sequencer #(.PROG_LEN(PROG_LEN), .RESET_PC(0)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .ins            (ins),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ins         (id_ins),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: word 0 is 32'h00220020, later words differ per index.
    function automatic logic [31:0] progWord(input int a);
        logic [15:0] a16;
        a16 = 16'(a);
        if (a < PROG_LEN) return 32'h00220020 + {4'h0, a16, 12'h000};
        return 32'hDEAD0000 | {16'h0000, a16};
    endfunction

    // Instruction memory with a registered one-cycle read.
    always @(posedge clk) begin
        ins <= progWord(int'(mem_addr));
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive inputs for the next rising edge, then return on the falling edge.
    task automatic applyStimulus(input bit r, input bit rdy, input bit rv, input int rpc);
        rst            = r;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = 16'(rpc);
        @(negedge clk);
    endtask

    task automatic waitForPc(input int target, input int bound);
        bit found;
        found = 0;
        for (int i = 0; i < bound; i++) begin
            if (id_valid && int'(id_pc) == target) begin
                found = 1;
                break;
            end
            applyStimulus(0, 1, 0, 0);
        end
        if (!found && id_valid && int'(id_pc) == target) found = 1;
        checkOutput($sformatf("reach pc %0d", target), found, 1);
    endtask

    task automatic waitValid(input int bound, output int cycles);
        cycles = 0;
        while (!id_valid && cycles < bound) begin
            applyStimulus(0, 1, 0, 0);
            cycles++;
        end
        checkOutput("wait id_valid", id_valid, 1);
    endtask

    // Reference model: apply the fetch rules once per rising edge.
    always @(posedge clk) begin
        bit pop;
        bit issue;
        int occ;
        if (rst) begin
            m_pc    = 0;
            m_infl  = 0;
            m_buf_pc.delete();
            m_halt  = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            pop = (m_buf_pc.size() > 0) && id_ready;
            if (m_buf_pc.size() > 0 && !id_ready) m_stall++;
            if (redirect_valid) begin
                m_flush += m_buf_pc.size() + int'(m_infl) - int'(pop);
                m_buf_pc.delete();
                m_infl = 0;
                m_pc   = int'(redirect_pc);
                m_halt = 0;
            end else begin
                occ   = m_buf_pc.size() + int'(m_infl) - int'(pop);
                issue = !m_halt && (m_pc < PROG_LEN) && (occ < 2);
                if (pop) void'(m_buf_pc.pop_front());
                if (m_infl) m_buf_pc.push_back(m_infl_pc);
                m_infl = issue;
                if (issue) begin
                    m_infl_pc = m_pc;
                    m_pc++;
                end
                if (m_pc >= PROG_LEN && !m_infl && m_buf_pc.size() == 0) m_halt = 1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model mem_addr", mem_addr, m_pc);
            checkOutput("model halted", halted, m_halt);
            checkOutput("model id_valid", id_valid, m_buf_pc.size() > 0);
            if (m_buf_pc.size() > 0) begin
                checkOutput("model id_pc", id_pc, m_buf_pc[0]);
                checkOutput("model id_ins", id_ins, progWord(m_buf_pc[0]));
            end
`ifdef FETCH_PERF_CNT_EN
            checkOutput("model perf_stall", perf_stall, m_stall);
            checkOutput("model perf_flush", perf_flush, m_flush);
`endif
        end
    end

    initial begin
        int cycles;
        longint s0;
        longint f0;
        s0 = 0;
        f0 = 0;
        rst            = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        applyStimulus(1, 1, 0, 0);
        chk_en = 1;
        applyStimulus(1, 1, 0, 0);
        checkOutput("reset id_valid", id_valid, 0);
        checkOutput("reset id_ins", id_ins, 0);
        checkOutput("reset id_pc", id_pc, 0);
        checkOutput("reset halted", halted, 0);
        checkOutput("reset mem_addr", mem_addr, 0);

        // Straight-line run through the whole image with decode always ready.
        applyStimulus(0, 1, 0, 0);
        checkOutput("first cycle id_valid", id_valid, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("first id_valid", id_valid, 1);
        checkOutput("first id_pc", id_pc, 0);
        checkOutput("first id_ins", id_ins, 32'h00220020);
        for (int k = 1; k < PROG_LEN; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("stream id_valid", id_valid, 1);
            checkOutput("stream id_pc", id_pc, k);
        end
        applyStimulus(0, 1, 0, 0);
        checkOutput("end halted", halted, 1);
        checkOutput("end id_valid", id_valid, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("halt mem_addr", mem_addr, PROG_LEN);

        // Redirect out of HALT back to the start of the image.
        applyStimulus(0, 1, 1, 0);
        checkOutput("restart halted", halted, 0);
        waitValid(6, cycles);
        checkOutput("restart id_pc", id_pc, 0);

        // Five cycles of back-pressure with pc 3 at the head.
        waitForPc(3, 12);
        checkOutput("bp entry mem_addr", mem_addr, 5);
`ifdef FETCH_PERF_CNT_EN
        s0 = perf_stall;
`endif
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("bp hold id_pc", id_pc, 3);
        end
        checkOutput("bp mem_addr", mem_addr, 5);
        checkOutput("bp buffer count", u_dut.buf_count, 2);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("bp perf_stall delta", perf_stall - s0, 5);
`endif
        for (int k = 4; k <= 7; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("bp release id_pc", id_pc, k);
        end

        // Redirect to 20 while 7 and 8 sit in the buffer.
        waitForPc(7, 4);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre redirect count", u_dut.buf_count, 2);
        checkOutput("pre redirect mem_addr", mem_addr, 9);
`ifdef FETCH_PERF_CNT_EN
        f0 = perf_flush;
`endif
        applyStimulus(0, 0, 1, 20);
        checkOutput("post redirect id_valid", id_valid, 0);
        checkOutput("post redirect mem_addr", mem_addr, 20);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("redirect perf_flush delta", perf_flush - f0, 2);
`endif
        waitValid(4, cycles);
        checkOutput("redirect latency", cycles, 2);
        checkOutput("redirect first id_pc", id_pc, 20);
        applyStimulus(0, 1, 0, 0);
        checkOutput("redirect second id_pc", id_pc, 21);

        // Redirect to 2 in the same cycle pc 10 is accepted.
        applyStimulus(0, 1, 1, 8);
        waitForPc(10, 10);
`ifdef FETCH_PERF_CNT_EN
        f0 = perf_flush;
`endif
        applyStimulus(0, 1, 1, 2);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("handshake redirect perf_flush delta", perf_flush - f0, 1);
`endif
        waitValid(4, cycles);
        checkOutput("handshake redirect id_pc", id_pc, 2);

        // Redirect beyond the image halts one cycle later.
        applyStimulus(0, 1, 1, PROG_LEN + 5);
        checkOutput("far redirect halted early", halted, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("far redirect halted", halted, 1);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 1500; i++) begin
            bit r;
            bit rdy;
            bit rv;
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            applyStimulus(r, rdy, rv, $urandom_range(0, PROG_LEN + 3));
        end
        applyStimulus(0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
